// File: rtl/hood_mode_controller.sv
// rtl/hood_mode_controller.sv - range-hood operating state machine with timed levels and long-press off
// Registered state, seconds countdown and one-shot storm flag.
module hood_mode_controller #(
  parameter int STORM_S     = 60,
  parameter int WAIT_S      = 60,
  parameter int CLEAN_S     = 180,
  parameter int LONGPRESS_S = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1s,
  input  logic             power_btn,
  input  logic             menu_pulse,
  input  logic             lvl1_pulse,
  input  logic             lvl2_pulse,
  input  logic             lvl3_pulse,
  input  logic             clean_pulse,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] countdown,
  output logic             storm_used
);

  localparam logic [2:0] S_OFF     = 3'b000;
  localparam logic [2:0] S_STANDBY = 3'b001;
  localparam logic [2:0] S_MODE    = 3'b010;
  localparam logic [2:0] S_FIRST   = 3'b011;
  localparam logic [2:0] S_SECOND  = 3'b100;
  localparam logic [2:0] S_THIRD   = 3'b101;
  localparam logic [2:0] S_CLEAN   = 3'b110;
  localparam logic [2:0] S_WAIT    = 3'b111;

  localparam int HOLD_W = $clog2(LONGPRESS_S + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONGPRESS_S - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  countdown_q, countdown_d;
  logic              storm_used_q, storm_used_d;
  logic              pwr_prev_q, pwr_prev_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_armed_q, hold_armed_d;

  logic timed;
  logic long_press;
  logic expire;

  assign timed      = (state_q == S_THIRD) || (state_q == S_WAIT) || (state_q == S_CLEAN);
  assign long_press = power_btn && hold_armed_q && tick_1s && (hold_cnt_q == HOLD_LAST);
  assign expire     = timed && tick_1s && (countdown_q == CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    countdown_d  = countdown_q;
    storm_used_d = storm_used_q;
    pwr_prev_d   = power_btn;
    hold_armed_d = hold_armed_q;
    hold_cnt_d   = hold_cnt_q;

    if (!power_btn || !hold_armed_q) begin
      hold_cnt_d = '0;
    end else if (tick_1s) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
    // Arming only after a release keeps the power-on press from also powering off.
    if (state_q != S_OFF && !power_btn) begin
      hold_armed_d = 1'b1;
    end

    if (state_q == S_OFF) begin
      if (power_btn && !pwr_prev_q) begin
        state_d      = S_STANDBY;
        hold_armed_d = 1'b0;
      end
    end else if (long_press) begin
      state_d      = S_OFF;
      countdown_d  = '0;
      storm_used_d = 1'b0;
      hold_cnt_d   = '0;
      hold_armed_d = 1'b0;
    end else if (expire) begin
      state_d     = (state_q == S_THIRD) ? S_SECOND : S_STANDBY;
      countdown_d = '0;
    end else begin
      if (timed && tick_1s && countdown_q != '0) begin
        countdown_d = countdown_q - CNT_W'(1);
      end
      case (state_q)
        S_STANDBY: begin
          if (menu_pulse) state_d = S_MODE;
        end
        S_MODE: begin
          if (menu_pulse) begin
            state_d = S_STANDBY;
          end else if (clean_pulse) begin
            state_d     = S_CLEAN;
            countdown_d = CNT_W'(CLEAN_S);
          end else if (lvl3_pulse && !storm_used_q) begin
            state_d      = S_THIRD;
            countdown_d  = CNT_W'(STORM_S);
            storm_used_d = 1'b1;
          end else if (lvl2_pulse) begin
            state_d = S_SECOND;
          end else if (lvl1_pulse) begin
            state_d = S_FIRST;
          end
        end
        S_FIRST: begin
          if (menu_pulse) state_d = S_STANDBY;
          else if (lvl2_pulse) state_d = S_SECOND;
        end
        S_SECOND: begin
          if (menu_pulse) state_d = S_STANDBY;
          else if (lvl1_pulse) state_d = S_FIRST;
        end
        S_THIRD: begin
          if (menu_pulse) begin
            state_d     = S_WAIT;
            countdown_d = CNT_W'(WAIT_S);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      countdown_q  <= '0;
      storm_used_q <= 1'b0;
      pwr_prev_q   <= 1'b0;
      hold_cnt_q   <= '0;
      hold_armed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      countdown_q  <= countdown_d;
      storm_used_q <= storm_used_d;
      pwr_prev_q   <= pwr_prev_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_armed_q <= hold_armed_d;
    end
  end

  assign state      = state_q;
  assign countdown  = countdown_q;
  assign storm_used = storm_used_q;

endmodule

// File: tb/tb_hood_mode_controller.sv
// tb/tb_hood_mode_controller.sv - randomized and directed checks of hood_mode_controller against a table-driven model
// The model picks the first acting button from a priority list and applies per-target loads.
module tb_hood_mode_controller;

  localparam int STORM_S = 60;
  localparam int WAIT_S  = 60;
  localparam int CLEAN_S = 180;
  localparam int LP_S    = 3;

  localparam int ST_OFF = 0, ST_STBY = 1, ST_MODE = 2, ST_L1 = 3;
  localparam int ST_L2 = 4, ST_L3 = 5, ST_CLEAN = 6, ST_WAIT = 7;

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_MENU  = 5'b10000;
  localparam logic [4:0] B_CLEAN = 5'b01000;
  localparam logic [4:0] B_L3    = 5'b00100;
  localparam logic [4:0] B_L2    = 5'b00010;
  localparam logic [4:0] B_L1    = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_1s = 1'b0, power_btn = 1'b0;
  logic menu_pulse = 1'b0, lvl1_pulse = 1'b0, lvl2_pulse = 1'b0, lvl3_pulse = 1'b0, clean_pulse = 1'b0;
  logic [2:0] state;
  logic [7:0] countdown;
  logic storm_used;

  int total = 0;
  int bad = 0;

  int m_state = ST_OFF, m_cd = 0, m_hold = 0;
  bit m_su = 0, m_prev = 0, m_armed = 0;

  always #5 clk = ~clk;

  hood_mode_controller #(
    .STORM_S(STORM_S), .WAIT_S(WAIT_S), .CLEAN_S(CLEAN_S), .LONGPRESS_S(LP_S), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .power_btn(power_btn),
    .menu_pulse(menu_pulse), .lvl1_pulse(lvl1_pulse), .lvl2_pulse(lvl2_pulse),
    .lvl3_pulse(lvl3_pulse), .clean_pulse(clean_pulse),
    .state(state), .countdown(countdown), .storm_used(storm_used)
  );

  // Where button idx (0=menu,1=clean,2=lvl3,3=lvl2,4=lvl1) leads from state s; -1 means no effect.
  function automatic int react(int s, int idx, bit su);
    case (s)
      ST_STBY: return (idx == 0) ? ST_MODE : -1;
      ST_MODE: begin
        case (idx)
          0: return ST_STBY;
          1: return ST_CLEAN;
          2: return su ? -1 : ST_L3;
          3: return ST_L2;
          default: return ST_L1;
        endcase
      end
      ST_L1: return (idx == 0) ? ST_STBY : (idx == 3) ? ST_L2 : -1;
      ST_L2: return (idx == 0) ? ST_STBY : (idx == 4) ? ST_L1 : -1;
      ST_L3: return (idx == 0) ? ST_WAIT : -1;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    bit pressed [5];
    int ns, ncd, nhold, tgt;
    bit nsu, narmed, timed, held;
    pressed = '{menu_pulse, clean_pulse, lvl3_pulse, lvl2_pulse, lvl1_pulse};
    ns = m_state; ncd = m_cd; nsu = m_su; narmed = m_armed;
    timed = (m_state == ST_L3) || (m_state == ST_WAIT) || (m_state == ST_CLEAN);
    held = power_btn && m_armed;
    nhold = held ? m_hold + int'(tick_1s) : 0;
    if (m_state != ST_OFF && !power_btn) narmed = 1;
    if (m_state == ST_OFF) begin
      if (power_btn && !m_prev) begin
        ns = ST_STBY;
        narmed = 0;
      end
    end else if (held && tick_1s && nhold == LP_S) begin
      ns = ST_OFF; ncd = 0; nsu = 0; nhold = 0; narmed = 0;
    end else if (timed && tick_1s && m_cd == 1) begin
      ns = (m_state == ST_L3) ? ST_L2 : ST_STBY;
      ncd = 0;
    end else begin
      if (timed && tick_1s && m_cd > 0) ncd = m_cd - 1;
      tgt = -1;
      for (int i = 0; i < 5; i++) begin
        if (tgt < 0 && pressed[i]) tgt = react(m_state, i, m_su);
      end
      if (tgt >= 0) begin
        ns = tgt;
        if (tgt == ST_L3) begin ncd = STORM_S; nsu = 1; end
        if (tgt == ST_WAIT) ncd = WAIT_S;
        if (tgt == ST_CLEAN) ncd = CLEAN_S;
      end
    end
    m_state <= ns; m_cd <= ncd; m_su <= nsu; m_hold <= nhold; m_armed <= narmed;
    m_prev <= power_btn;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= ST_OFF; m_cd <= 0; m_su <= 0; m_hold <= 0; m_armed <= 0; m_prev <= 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    total++;
    if (int'(state) != m_state || int'(countdown) != m_cd || storm_used != m_su) begin
      bad++;
      $display("FAIL model t=%0t state=%0d/%0d countdown=%0d/%0d storm_used=%0d/%0d (dut/model)",
               $time, state, m_state, countdown, m_cd, storm_used, m_su);
    end
  end

  task automatic step(input logic [4:0] b, input logic t);
    {menu_pulse, clean_pulse, lvl3_pulse, lvl2_pulse, lvl1_pulse} = b;
    tick_1s = t;
    @(negedge clk);
    #1;
    {menu_pulse, clean_pulse, lvl3_pulse, lvl2_pulse, lvl1_pulse} = B_NONE;
    tick_1s = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(B_NONE, 1'b1);
  endtask

  task automatic lit(input string name, input int st, input int cd, input int su);
    total++;
    if (int'(state) != st || int'(countdown) != cd || int'(storm_used) != su) begin
      bad++;
      $display("FAIL %s got state=%0d cd=%0d su=%0d want state=%0d cd=%0d su=%0d",
               name, state, countdown, storm_used, st, cd, su);
    end
  endtask

  // From any armed non-OFF state with power released: long-press off, then power back on and arm.
  task automatic power_cycle();
    power_btn = 1'b1; step(B_NONE, 1'b0);
    ticks(LP_S);
    power_btn = 1'b0; step(B_NONE, 1'b0);
    power_btn = 1'b1; step(B_NONE, 1'b0);
    power_btn = 1'b0; step(B_NONE, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rb;
    @(negedge clk); #1;
    step(B_NONE, 1'b0);
    lit("reset", 0, 0, 0);
    rst_n = 1'b1;
    step(B_NONE, 1'b0);

    power_btn = 1'b1; step(B_NONE, 1'b0);
    lit("power_on", 1, 0, 0);
    ticks(5);
    lit("unarmed_hold", 1, 0, 0);
    power_btn = 1'b0; step(B_NONE, 1'b0);
    power_btn = 1'b1; step(B_NONE, 1'b0);
    ticks(2);
    lit("hold_two_ticks", 1, 0, 0);
    ticks(1);
    lit("long_press_off", 0, 0, 0);

    power_btn = 1'b0; step(B_NONE, 1'b0);
    power_btn = 1'b1; step(B_NONE, 1'b0);
    power_btn = 1'b0; step(B_NONE, 1'b0);
    step(B_MENU, 1'b0);
    lit("mode_select", 2, 0, 0);
    step(B_L3, 1'b0);
    lit("storm_enter", 5, 60, 1);
    ticks(59);
    lit("storm_cd1", 5, 1, 1);
    ticks(1);
    lit("storm_expire", 4, 0, 1);
    step(B_MENU, 1'b0);
    step(B_MENU, 1'b0);
    step(B_L3, 1'b0);
    lit("storm_rejected", 2, 0, 1);
    step(B_L3 | B_L2, 1'b0);
    lit("storm_falls_to_l2", 4, 0, 1);
    step(B_MENU, 1'b0);
    lit("l2_to_standby", 1, 0, 1);

    power_cycle();
    lit("power_cycle_clears_storm", 1, 0, 0);
    step(B_MENU, 1'b0);
    step(B_L3, 1'b0);
    ticks(15);
    lit("storm_cd45", 5, 45, 1);
    step(B_MENU | B_L1 | B_CLEAN, 1'b1);
    lit("wait_enter", 7, 60, 1);
    step(B_MENU, 1'b1);
    lit("wait_ignores_buttons", 7, 59, 1);
    ticks(58);
    lit("wait_cd1", 7, 1, 1);
    ticks(1);
    lit("wait_expire", 1, 0, 1);

    step(B_MENU, 1'b0);
    step(B_CLEAN | B_L3, 1'b0);
    lit("clean_enter", 6, 180, 1);
    step(B_L1, 1'b0); step(B_L2, 1'b0); step(B_MENU, 1'b0); step(B_L3, 1'b0);
    lit("clean_ignores", 6, 180, 1);
    ticks(180);
    lit("clean_expire", 1, 0, 1);

    power_cycle();
    step(B_MENU, 1'b0);
    step(B_L3, 1'b0);
    ticks(59);
    step(B_MENU, 1'b1);
    lit("expiry_beats_menu", 4, 0, 1);

    step(B_MENU, 1'b0);
    step(B_MENU, 1'b0);
    step(B_CLEAN, 1'b0);
    ticks(80);
    lit("clean_cd100", 6, 100, 1);
    power_btn = 1'b1; step(B_NONE, 1'b0);
    ticks(2);
    lit("clean_hold_two", 6, 98, 1);
    ticks(1);
    lit("clean_long_press_off", 0, 0, 0);

    power_btn = 1'b0; step(B_NONE, 1'b0);
    power_btn = 1'b1; step(B_NONE, 1'b0);
    power_btn = 1'b0; step(B_NONE, 1'b0);
    step(B_MENU, 1'b0);
    step(B_L1, 1'b0);
    lit("first_level", 3, 0, 0);
    rst_n = 1'b0;
    #2;
    lit("async_reset", 0, 0, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    step(B_NONE, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) power_btn = ~power_btn;
      rb = B_NONE;
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 9) == 0) rb[k] = 1'b1;
      end
      step(rb, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hood_mode_controller.md
Name: hood_mode_controller

Overview:
- Main range-hood operating state machine. Produces the 3-bit `state` code that is consumed by the power/working/clean/standby indicator stage, plus the seconds countdown shown on the display.
- Inputs are debounced single-cycle button pulses, a debounced power-button level, and a 1 Hz tick from the timebase.
- Enforces the one-shot storm level, the timed returns, self-clean timing, and the long-press power-off.

Parameters:
- STORM_S, 60, third-level (storm) run time in seconds before automatic drop to second level
- WAIT_S, 60, delay from leaving storm mode until standby, in seconds
- CLEAN_S, 180, self-clean duration in seconds
- LONGPRESS_S, 3, power-button hold time in ticks that forces OFF
- CNT_W, 8, countdown width; must hold max(STORM_S, WAIT_S, CLEAN_S)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_1s  in  1  one-cycle pulse, once per second
- power_btn  in  1  debounced power button level, 1 = pressed
- menu_pulse  in  1  one-cycle menu button press
- lvl1_pulse  in  1  one-cycle level-1 press
- lvl2_pulse  in  1  one-cycle level-2 press
- lvl3_pulse  in  1  one-cycle level-3 press
- clean_pulse  in  1  one-cycle self-clean press
- state  out  3  OFF=000, STANDBY=001, MODE_SELECT=010, FIRST_LEVEL=011, SECOND_LEVEL=100, THIRD_LEVEL=101, SELF_CLEAN=110, WAIT_TO_STANDBY=111
- countdown  out  CNT_W  seconds remaining in timed states, otherwise 0
- storm_used  out  1  third level already consumed this power cycle

Behaviour:
- Reset (async, rst_n=0):
  - state=OFF, countdown=0, storm_used=0.
  - Internal power_btn previous-sample register=0, hold_cnt=0, hold_armed=0.
- All outputs are registered. A state change is visible the cycle after the causing input.

Power-on and power-off:
- Power-on: in OFF, a rising edge of power_btn (previous sample 0, current 1) moves to STANDBY. hold_armed=0 on entry.
- hold_armed:
  - Set on the first cycle power_btn=0 while state!=OFF.
  - Prevents the same press that powered the unit on from also powering it off.
- hold_cnt:
  - Cleared whenever power_btn=0 or hold_armed=0.
  - Otherwise incremented on each tick_1s.
- Long-press off: when hold_cnt would reach LONGPRESS_S in any non-OFF state, move to OFF. Same cycle: countdown=0, storm_used=0, hold_cnt=0, hold_armed=0.
- A rising edge of power_btn in a non-OFF state does nothing by itself.

Transitions (button priority within a cycle: menu > clean > lvl3 > lvl2 > lvl1; unlisted buttons are ignored):
- STANDBY: menu -> MODE_SELECT.
- MODE_SELECT:
  - menu -> STANDBY.
  - clean -> SELF_CLEAN, countdown=CLEAN_S.
  - lvl3 -> THIRD_LEVEL, countdown=STORM_S, storm_used=1. Only if storm_used=0; otherwise ignored and lower-priority buttons in the same cycle are evaluated.
  - lvl2 -> SECOND_LEVEL.
  - lvl1 -> FIRST_LEVEL.
- FIRST_LEVEL: menu -> STANDBY; lvl2 -> SECOND_LEVEL.
- SECOND_LEVEL: menu -> STANDBY; lvl1 -> FIRST_LEVEL.
- THIRD_LEVEL:
  - menu -> WAIT_TO_STANDBY, countdown=WAIT_S.
  - Level and clean buttons ignored.
  - Expiry -> SECOND_LEVEL, countdown=0.
- WAIT_TO_STANDBY: all buttons ignored; expiry -> STANDBY.
- SELF_CLEAN: all buttons ignored; expiry -> STANDBY.

Countdown:
- In timed states (THIRD_LEVEL, WAIT_TO_STANDBY, SELF_CLEAN), countdown decrements by 1 on each tick_1s.
- Expiry is tick_1s while countdown==1: transition and countdown=0 in the same cycle. countdown never wraps below 0.
- A tick_1s in the cycle a countdown is loaded is ignored; the load wins.
- Simultaneous events, highest priority first: long-press off > countdown expiry > button. Example: menu and expiry in the same THIRD_LEVEL cycle -> SECOND_LEVEL.
- storm_used holds through STANDBY and MODE_SELECT. It is cleared only by OFF or reset.
- Reset mid-operation returns to OFF immediately, regardless of state or countdown.

Test Plan:
- Reset, then power_btn 0->1 -> state 001 next cycle. Keep holding 5 ticks -> still 001 (not armed). Release, press and hold 3 ticks -> state 000, storm_used 0.
- STANDBY, menu, lvl3 -> state 101, countdown 60, storm_used 1. After 60 ticks -> state 100, countdown 0. menu, menu, lvl3 -> stays 010 (storm rejected).
- In THIRD_LEVEL at countdown 45, menu -> state 111, countdown 60. 60 ticks later -> state 001.
- MODE_SELECT, clean -> state 110, countdown 180. Level/menu presses are ignored. 180 ticks -> state 001, countdown 0.
- THIRD_LEVEL at countdown 1, menu and tick_1s in the same cycle -> state 100, countdown 0.
- SELF_CLEAN at countdown 100, armed long press of 3 ticks -> state 000, countdown 0. Assert rst_n=0 in FIRST_LEVEL -> state 000 asynchronously.
